// File: rtl/fft_bfly_r2.sv
// Pipelined radix-2 DIT butterfly: X0 = A + B*W, X1 = A - B*W. It has three register stages,
// round-half-up, optional divide-by-2, saturation with a sticky flag, and valid/ready flow.
module fft_bfly_r2 #(
  parameter int DATA_WIDTH    = 32,
  parameter int TWIDDLE_WIDTH = 9,
  parameter int SCALE         = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    a_re,
  input  logic [DATA_WIDTH-1:0]    a_im,
  input  logic [DATA_WIDTH-1:0]    b_re,
  input  logic [DATA_WIDTH-1:0]    b_im,
  input  logic [TWIDDLE_WIDTH-1:0] w_cos,
  input  logic [TWIDDLE_WIDTH-1:0] w_sin,
  input  logic                     inv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    x0_re,
  output logic [DATA_WIDTH-1:0]    x0_im,
  output logic [DATA_WIDTH-1:0]    x1_re,
  output logic [DATA_WIDTH-1:0]    x1_im,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int DW  = DATA_WIDTH;
  localparam int TW  = TWIDDLE_WIDTH;
  localparam int PW  = DW + TW;
  localparam int SW  = PW + 1;
  localparam int TWW = DW + 2;
  localparam int UW  = DW + 3;

  localparam logic signed [SW-1:0] RND   = {{(SW-1){1'b0}}, 1'b1} << (TW - 3);
  localparam logic signed [UW-1:0] ONE   = {{(UW-1){1'b0}}, 1'b1};
  localparam logic signed [UW-1:0] MAXV  = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [UW-1:0] MINV  = {4'b1111, {(DW-1){1'b0}}};

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic signed [TW-1:0] s_sel;
  logic signed [PW-1:0] bre_x, bim_x, cos_x, s_x;

  // The min-negative w_sin wraps on negation; the twiddle ROM never produces it.
  assign s_sel = inv ? -$signed(w_sin) : $signed(w_sin);
  assign bre_x = PW'($signed(b_re));
  assign bim_x = PW'($signed(b_im));
  assign cos_x = PW'($signed(w_cos));
  assign s_x   = PW'(s_sel);

  logic                 v1, v2;
  logic signed [DW-1:0] a1_re, a1_im, a2_re, a2_im;
  logic signed [PW-1:0] p_rc, p_is, p_rs, p_ic;
  logic signed [TWW-1:0] t_re, t_im;
  logic signed [SW-1:0] t_re_full, t_im_full;

  assign t_re_full = SW'(p_rc) - SW'(p_is) + RND;
  assign t_im_full = SW'(p_rs) + SW'(p_ic) + RND;

  logic signed [UW-1:0] u [4];
  logic signed [UW-1:0] v [4];
  logic [DW-1:0]        y [4];
  logic [3:0]           sat_v;

  // Stage-3 sums, optional halving and clamp to the output range
  always_comb begin
    u[0] = UW'(a2_re) + UW'(t_re);
    u[1] = UW'(a2_im) + UW'(t_im);
    u[2] = UW'(a2_re) - UW'(t_re);
    u[3] = UW'(a2_im) - UW'(t_im);
    sat_v = '0;
    for (int k = 0; k < 4; k++) begin
      v[k] = u[k];
      y[k] = '0;
      if (SCALE != 0) v[k] = (u[k] + ONE) >>> 1;
      if (v[k] > MAXV) begin
        y[k]     = MAXV[DW-1:0];
        sat_v[k] = 1'b1;
      end else if (v[k] < MINV) begin
        y[k]     = MINV[DW-1:0];
        sat_v[k] = 1'b1;
      end else begin
        y[k] = v[k][DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      a1_re     <= '0;
      a1_im     <= '0;
      a2_re     <= '0;
      a2_im     <= '0;
      p_rc      <= '0;
      p_is      <= '0;
      p_rs      <= '0;
      p_ic      <= '0;
      t_re      <= '0;
      t_im      <= '0;
      x0_re     <= '0;
      x0_im     <= '0;
      x1_re     <= '0;
      x1_im     <= '0;
    end else if (en) begin
      v1        <= in_valid;
      a1_re     <= $signed(a_re);
      a1_im     <= $signed(a_im);
      p_rc      <= bre_x * cos_x;
      p_is      <= bim_x * s_x;
      p_rs      <= bre_x * s_x;
      p_ic      <= bim_x * cos_x;
      v2        <= v1;
      a2_re     <= a1_re;
      a2_im     <= a1_im;
      t_re      <= TWW'(t_re_full >>> (TW - 2));
      t_im      <= TWW'(t_im_full >>> (TW - 2));
      out_valid <= v2;
      if (v2) begin
        x0_re <= y[0];
        x0_im <= y[1];
        x1_re <= y[2];
        x1_im <= y[3];
      end
    end
  end

  // Only a valid result entering the output register can set the flag, so a stall never recounts it
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (en && v2 && (|sat_v)) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_fft_bfly_r2.sv
// Bench for fft_bfly_r2 at 16/9 bits: SCALE=0 and SCALE=1 instances share stimulus and are
// checked against directed vectors and an integer reference model with a scoreboard.
module tb_fft_bfly_r2;

  localparam int DW = 16;
  localparam int TW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, inv, out_ready, ovf_clr;
  logic [DW-1:0] a_re, a_im, b_re, b_im;
  logic [TW-1:0] w_cos, w_sin;

  logic r0_in_ready, r0_out_valid, r0_ovf;
  logic [DW-1:0] r0_x0_re, r0_x0_im, r0_x1_re, r0_x1_im;
  logic r1_in_ready, r1_out_valid, r1_ovf;
  logic [DW-1:0] r1_x0_re, r1_x0_im, r1_x1_re, r1_x1_im;

  fft_bfly_r2 #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0_in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_cos(w_cos), .w_sin(w_sin), .inv(inv),
    .out_valid(r0_out_valid), .out_ready(out_ready),
    .x0_re(r0_x0_re), .x0_im(r0_x0_im), .x1_re(r0_x1_re), .x1_im(r0_x1_im),
    .ovf(r0_ovf), .ovf_clr(ovf_clr));

  fft_bfly_r2 #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1_in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_cos(w_cos), .w_sin(w_sin), .inv(inv),
    .out_valid(r1_out_valid), .out_ready(out_ready),
    .x0_re(r1_x0_re), .x0_im(r1_x0_im), .x1_re(r1_x1_re), .x1_im(r1_x1_im),
    .ovf(r1_ovf), .ovf_clr(ovf_clr));

  typedef struct {
    int are, aim, bre, bim, c, s, iv;
    int s0_x0r, s0_x0i, s0_x1r, s0_x1i;
    int s1_x0r, s1_x0i, s1_x1r, s1_x1i;
    int eovf0;
  } vec_t;

  typedef struct {
    longint x0r, x0i, x1r, x1i;
    bit     sat;
  } res_t;

  int checks = 0;
  int errors = 0;
  res_t q0[$];
  res_t q1[$];
  bit satAny0, satAny1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Butterfly computed from its arithmetic definition with 64-bit integers
  function automatic res_t model(input longint ar, ai, br, bi, c, s, input bit iv, input bit scl);
    res_t r;
    longint sv, tr, ti;
    longint u[4];
    sv = iv ? -s : s;
    tr = (br * c - bi * sv + (64'sd1 <<< (TW - 3))) >>> (TW - 2);
    ti = (br * sv + bi * c + (64'sd1 <<< (TW - 3))) >>> (TW - 2);
    u[0] = ar + tr;
    u[1] = ai + ti;
    u[2] = ar - tr;
    u[3] = ai - ti;
    r.sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (scl) u[k] = (u[k] + 1) >>> 1;
      if (u[k] > 32767) begin u[k] = 32767; r.sat = 1'b1; end
      else if (u[k] < -32768) begin u[k] = -32768; r.sat = 1'b1; end
    end
    r.x0r = u[0]; r.x0i = u[1]; r.x1r = u[2]; r.x1i = u[3];
    return r;
  endfunction

  task automatic driveData(input longint ar, ai, br, bi, c, s, input bit iv);
    a_re  = DW'(ar);
    a_im  = DW'(ai);
    b_re  = DW'(br);
    b_im  = DW'(bi);
    w_cos = TW'(c);
    w_sin = TW'(s);
    inv   = iv;
  endtask

  task automatic checkRes(input string tag, input res_t e,
                          input logic [DW-1:0] x0r, x0i, x1r, x1i);
    checkOutput({tag, "_x0re"}, longint'($signed(x0r)), e.x0r);
    checkOutput({tag, "_x0im"}, longint'($signed(x0i)), e.x0i);
    checkOutput({tag, "_x1re"}, longint'($signed(x1r)), e.x1r);
    checkOutput({tag, "_x1im"}, longint'($signed(x1i)), e.x1i);
  endtask

  // One directed pair through an otherwise idle pipe, then an ovf_clr pulse
  task automatic applyStimulus(input int idx, input vec_t v);
    res_t e0, e1;
    int lat;
    string tag;
    tag = $sformatf("vec%0d", idx);
    e0.x0r = v.s0_x0r; e0.x0i = v.s0_x0i; e0.x1r = v.s0_x1r; e0.x1i = v.s0_x1i; e0.sat = 1'b0;
    e1.x0r = v.s1_x0r; e1.x0i = v.s1_x0i; e1.x1r = v.s1_x1r; e1.x1i = v.s1_x1i; e1.sat = 1'b0;
    @(negedge clk);
    driveData(v.are, v.aim, v.bre, v.bim, v.c, v.s, v.iv[0]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!r0_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, 3);
    checkOutput({tag, "_s1_valid"}, r1_out_valid, 1);
    checkRes({tag, "_s0"}, e0, r0_x0_re, r0_x0_im, r0_x1_re, r0_x1_im);
    checkRes({tag, "_s1"}, e1, r1_x0_re, r1_x0_im, r1_x1_re, r1_x1_im);
    checkOutput({tag, "_ovf_s0"}, r0_ovf, v.eovf0);
    checkOutput({tag, "_ovf_s1"}, r1_ovf, 0);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checkOutput({tag, "_ovfclr_s0"}, r0_ovf, 0);
  endtask

  // One scoreboarded cycle with random data; reports whether the pair was accepted
  task automatic runCycle(input bit vld, input bit ordy, output bit acc);
    longint ar, ai, br, bi, c, s;
    bit iv;
    res_t e0, e1;
    ar = longint'($urandom_range(0, 65535)) - 32768;
    ai = longint'($urandom_range(0, 65535)) - 32768;
    br = longint'($urandom_range(0, 65535)) - 32768;
    bi = longint'($urandom_range(0, 65535)) - 32768;
    c  = longint'($urandom_range(0, 256)) - 128;
    s  = longint'($urandom_range(0, 256)) - 128;
    iv = 1'($urandom_range(0, 1));
    @(negedge clk);
    driveData(ar, ai, br, bi, c, s, iv);
    in_valid  = vld;
    out_ready = ordy;
    #1;
    checkOutput("in_ready", r0_in_ready, (!r0_out_valid || ordy) ? 1 : 0);
    if (r0_out_valid) begin
      if (q0.size() == 0) checkOutput("spurious_out_s0", 1, 0);
      else begin
        checkRes("sb_s0", q0[0], r0_x0_re, r0_x0_im, r0_x1_re, r0_x1_im);
        if (ordy) void'(q0.pop_front());
      end
    end
    if (r1_out_valid) begin
      if (q1.size() == 0) checkOutput("spurious_out_s1", 1, 0);
      else begin
        checkRes("sb_s1", q1[0], r1_x0_re, r1_x0_im, r1_x1_re, r1_x1_im);
        if (ordy) void'(q1.pop_front());
      end
    end
    acc = vld && r0_in_ready;
    if (acc) begin
      e0 = model(ar, ai, br, bi, c, s, iv, 1'b0);
      e1 = model(ar, ai, br, bi, c, s, iv, 1'b1);
      q0.push_back(e0);
      satAny0 |= e0.sat;
    end
    if (vld && r1_in_ready) begin
      e1 = model(ar, ai, br, bi, c, s, iv, 1'b1);
      q1.push_back(e1);
      satAny1 |= e1.sat;
    end
  endtask

  vec_t vecs[7];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit acc;
    int sent;
    int budget;

    vecs[0] = '{100, 0, 50, 0, 128, 0, 0,      150, 0, 50, 0,         75, 0, 25, 0,           0};
    vecs[1] = '{100, 0, 50, 20, 0, 128, 0,     80, 50, 120, -50,      40, 25, 60, -25,        0};
    vecs[2] = '{100, 0, 50, 20, 0, 128, 1,     120, -50, 80, 50,      60, -25, 40, 25,        0};
    vecs[3] = '{0, 0, 1, 0, 64, 0, 0,          1, 0, -1, 0,           1, 0, 0, 0,             0};
    vecs[4] = '{0, 0, -1, 0, 64, 0, 0,         0, 0, 0, 0,            0, 0, 0, 0,             0};
    vecs[5] = '{32767, 0, 32767, 0, 128, 0, 0, 32767, 0, 0, 0,        32767, 0, 0, 0,         1};
    vecs[6] = '{-32768, -32768, 32767, 0, 128, 0, 0,
                -1, -32768, -32768, -32768,   0, -16384, -32767, -16384,   1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    driveData(0, 0, 0, 0, 0, 0, 1'b0);
    satAny0 = 1'b0; satAny1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", r0_out_valid, 0);
    checkOutput("reset_in_ready", r0_in_ready, 1);
    checkOutput("reset_ovf", r0_ovf, 0);
    checkOutput("reset_x0re", longint'($signed(r0_x0_re)), 0);
    checkOutput("reset_x1im", longint'($signed(r0_x1_im)), 0);

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Saturating result lands while ovf_clr is held: the set wins, the clear takes the next cycle
    @(negedge clk);
    driveData(32767, 0, 32767, 0, 128, 0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("setwins_valid", r0_out_valid, 1);
    checkOutput("setwins_ovf", r0_ovf, 1);
    @(negedge clk);
    checkOutput("setwins_cleared", r0_ovf, 0);
    ovf_clr = 1'b0;

    // Backpressure: 8 pairs streamed, output stalled for six cycles after the first result
    sent = 0;
    for (int c = 1; c <= 60 && (sent < 8 || q0.size() > 0); c++) begin
      runCycle(sent < 8, !(c >= 4 && c <= 9), acc);
      if (acc) sent++;
      if (c == 3) checkOutput("bp_not_yet_valid", r0_out_valid, 0);
      if (c == 4) checkOutput("bp_valid_at_3", r0_out_valid, 1);
      if (c >= 4 && c <= 9) checkOutput("bp_in_ready_low", r0_in_ready, 0);
    end
    checkOutput("bp_sent", sent, 8);
    checkOutput("bp_drained_s0", q0.size(), 0);
    checkOutput("bp_drained_s1", q1.size(), 0);

    // Reset with two pairs in flight after a saturating result has set ovf
    @(negedge clk);
    driveData(32767, 0, 32767, 0, 128, 0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    driveData(10, 20, 30, 40, 128, 0, 1'b0);
    @(negedge clk);
    driveData(-5, 7, 9, -11, 0, 128, 1'b1);
    @(negedge clk);
    checkOutput("rst_pre_ovf", r0_ovf, 1);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", r0_out_valid, 0);
    checkOutput("rst_ovf", r0_ovf, 0);
    checkOutput("rst_in_ready", r0_in_ready, 1);
    checkOutput("rst_x0re", longint'($signed(r0_x0_re)), 0);
    checkOutput("rst_x0im", longint'($signed(r0_x0_im)), 0);
    checkOutput("rst_x1re", longint'($signed(r1_x1_re)), 0);
    @(negedge clk);
    checkOutput("rst_no_ghost1", r0_out_valid, 0);
    @(negedge clk);
    checkOutput("rst_no_ghost2", r0_out_valid, 0);
    applyStimulus(100, vecs[1]);

    // Random traffic with random backpressure against the reference model
    satAny0 = 1'b0; satAny1 = 1'b0;
    for (int c = 0; c < 400; c++) runCycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, acc);
    budget = 0;
    while ((q0.size() > 0 || q1.size() > 0) && budget < 50) begin
      runCycle(1'b0, 1'b1, acc);
      budget++;
    end
    checkOutput("rand_drained_s0", q0.size(), 0);
    checkOutput("rand_drained_s1", q1.size(), 0);
    checkOutput("rand_ovf_s0", r0_ovf, satAny0 ? 1 : 0);
    checkOutput("rand_ovf_s1", r1_ovf, satAny1 ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
